// File: rtl/riscv_store_pkg.sv
// Shared constants and types for the store sequencer: store funct3 codes,
// byte-lane base masks and the sequencer state encoding.
package riscv_store_pkg;

  localparam logic [6:0] OPC_STORE = 7'h23;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } seq_state_t;

endpackage

// File: rtl/store_sequencer_if.sv
// Store request channel and memory write-beat channel of the store sequencer.
// Both channels are valid/ready: a transfer happens on a rising edge where
// valid & ready are both high; once valid is raised, the payload holds until that edge.
interface store_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;

  modport master (
    output req_valid, req_funct3, req_addr, req_data,
    input  req_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_we,
    output mem_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_data,
    output req_ready,
    output mem_valid, mem_addr, mem_wdata, mem_we,
    input  mem_ready
  );
endinterface

// File: rtl/store_lane_align.sv
// Combinational byte-lane alignment: expands a store into an 8-bit mask and
// 64-bit shifted data spanning the addressed word and the one after it.
module store_lane_align
  import riscv_store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic        legal
);

  logic [3:0] base;

  always_comb begin
    legal = 1'b1;
    base  = MASK_W;
    case (funct3)
      F3_SB:   base = MASK_B;
      F3_SH:   base = MASK_H;
      F3_SW:   base = MASK_W;
      default: begin
        base  = 4'b0000;
        legal = 1'b0;
      end
    endcase
    m8  = {4'b0000, base} << off;
    d64 = {32'b0, data} << {off, 3'b000};
  end

endmodule

// File: rtl/store_sequencer.sv
// Turns store requests into one or two aligned word-write beats.
// Word-crossing stores are split only when STORE_SEQ_MISALIGN_EN is defined;
// otherwise they are rejected with an err pulse.
module store_sequencer
  import riscv_store_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  store_sequencer_if.slave bus,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] store_count,
  output seq_state_t       dbg_state
);

  seq_state_t        state;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic [31:0] a_data;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic        legal;
  logic        split_bad;

  assign bus.req_ready = (state == IDLE);
  assign dbg_state     = state;

  // While idle the aligner looks at the incoming request so the first beat can
  // be registered at accept; afterwards it works from the latched request.
  always_comb begin
    if (state == IDLE) begin
      a_funct3 = bus.req_funct3;
      a_off    = bus.req_addr[1:0];
      a_data   = bus.req_data;
    end else begin
      a_funct3 = r_funct3;
      a_off    = r_addr[1:0];
      a_data   = r_data;
    end
  end

  store_lane_align u_align (
    .funct3 (a_funct3),
    .off    (a_off),
    .data   (a_data),
    .m8     (m8),
    .d64    (d64),
    .legal  (legal)
  );

`ifdef STORE_SEQ_MISALIGN_EN
  assign split_bad = 1'b0;
`else
  logic unused_hi;
  assign split_bad = |m8[7:4];
  assign unused_hi = ^d64[63:32];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      store_count   <= '0;
      r_funct3      <= '0;
      r_addr        <= '0;
      r_data        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_data   <= bus.req_data;
            if (!legal || split_bad) begin
              err <= 1'b1;
            end else begin
              state         <= BEAT0;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_we    <= m8[3:0];
              bus.mem_wdata <= d64[31:0];
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
`ifdef STORE_SEQ_MISALIGN_EN
            if (|m8[7:4]) begin
              state         <= BEAT1;
              bus.mem_addr  <= bus.mem_addr + 32'd4;
              bus.mem_we    <= m8[7:4];
              bus.mem_wdata <= d64[63:32];
            end else begin
              state         <= IDLE;
              bus.mem_valid <= 1'b0;
              bus.mem_we    <= '0;
              done          <= 1'b1;
              store_count   <= store_count + 1'b1;
            end
`else
            state         <= IDLE;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= '0;
            done          <= 1'b1;
            store_count   <= store_count + 1'b1;
`endif
          end
        end
`ifdef STORE_SEQ_MISALIGN_EN
        BEAT1: begin
          if (bus.mem_ready) begin
            state         <= IDLE;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= '0;
            done          <= 1'b1;
            store_count   <= store_count + 1'b1;
          end
        end
`endif
        default: begin
          state         <= IDLE;
          bus.mem_valid <= 1'b0;
          bus.mem_we    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: byte-walk reference model checked every cycle,
// plus directed stores with literal beat expectations. Honors STORE_SEQ_MISALIGN_EN.
module tb_store_sequencer;
  import riscv_store_pkg::*;

`ifdef STORE_SEQ_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        done;
  logic        err;
  logic [15:0] store_count;
  seq_state_t  dbg_state;

  store_sequencer_if bus ();

  store_sequencer #(.CNT_W(16), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .done        (done),
    .err         (err),
    .store_count (store_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: expected beats {addr, we, wdata}
  logic [67:0] exp_q[$];
  logic [67:0] log_q[$];
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic [15:0] exp_cnt  = '0;
  int          done_cnt = 0;
  int          err_cnt  = 0;

  always @(negedge clk) begin
    logic        was_idle;
    logic        done_nx;
    logic        err_nx;
    logic [15:0] cnt_nx;
    int          size;
    int          nb;
    logic [31:0] ba;
    logic [31:0] wa;
    logic [31:0] b_addr[2];
    logic [3:0]  b_we[2];
    logic [63:0] wd;

    if (!rst_n) begin
      exp_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_cnt  = '0;
    end

    chk("done", {31'b0, done}, {31'b0, exp_done});
    chk("err", {31'b0, err}, {31'b0, exp_err});
    chk("store_count", {16'b0, store_count}, {16'b0, exp_cnt});
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_q.size() == 0});
    chk("mem_valid", {31'b0, bus.mem_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("mem_addr", bus.mem_addr, exp_q[0][67:36]);
      chk("mem_we", {28'b0, bus.mem_we}, {28'b0, exp_q[0][35:32]});
      chk("mem_wdata", bus.mem_wdata, exp_q[0][31:0]);
    end else begin
      chk("mem_we_idle", {28'b0, bus.mem_we}, 32'h0);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;

    if (rst_n) begin
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      cnt_nx   = exp_cnt;
      was_idle = (exp_q.size() == 0);
      if (!was_idle && bus.mem_ready) begin
        log_q.push_back({bus.mem_addr, bus.mem_we, bus.mem_wdata});
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          done_nx = 1'b1;
          cnt_nx  = exp_cnt + 16'd1;
        end
      end
      if (was_idle && bus.req_valid) begin
        case (bus.req_funct3)
          3'b000:  size = 1;
          3'b001:  size = 2;
          3'b010:  size = 4;
          default: size = 0;
        endcase
        if (size == 0) begin
          err_nx = 1'b1;
        end else begin
          // walk the stored bytes; each new word address opens a new beat
          nb = 0;
          for (int i = 0; i < size; i++) begin
            ba = bus.req_addr + 32'(i);
            wa = {ba[31:2], 2'b00};
            if (nb == 0 || wa != b_addr[nb-1]) begin
              b_addr[nb] = wa;
              b_we[nb]   = 4'b0000;
              nb++;
            end
            b_we[nb-1][ba[1:0]] = 1'b1;
          end
          wd = {32'b0, bus.req_data} << (8 * bus.req_addr[1:0]);
          if (nb > 1 && !MIS) begin
            err_nx = 1'b1;
          end else begin
            for (int k = 0; k < nb; k++)
              exp_q.push_back({b_addr[k], b_we[k], wd[32*k +: 32]});
          end
        end
      end
      exp_done = done_nx;
      exp_err  = err_nx;
      exp_cnt  = cnt_nx;
    end
  end

  // driver tasks
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_data   = data;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50; i++) begin
      if (bus.req_ready) break;
      @(posedge clk); #1;
    end
    if (i == 50) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic [31:0] a,
                          input logic [3:0] we, input logic [31:0] wd);
    if (idx < log_q.size()) begin
      chk({nm, "_addr"}, log_q[idx][67:36], a);
      chk({nm, "_we"}, {28'b0, log_q[idx][35:32]}, {28'b0, we});
      chk({nm, "_wdata"}, log_q[idx][31:0], wd);
    end else begin
      chk({nm, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  int e0;
  int d0;
  logic [15:0] c0;

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.mem_ready  = 1'b1;
    idle_cycles(3);
    chk("reset_count", {16'b0, store_count}, 32'h0);
    chk("reset_ready", {31'b0, bus.req_ready}, 32'h1);
    rst_n = 1'b1;
    idle_cycles(2);

    // SW aligned
    log_q.delete();
    do_store(F3_SW, 32'h100, 32'hDEADBEEF);
    wait_idle();
    chk("sw_nbeats", log_q.size(), 32'd1);
    chk_beat("sw", 0, 32'h100, 4'b1111, 32'hDEADBEEF);
    chk("sw_count", {16'b0, store_count}, 32'd1);
    idle_cycles(1);

    // SB at offset 3
    log_q.delete();
    do_store(F3_SB, 32'h203, 32'h000000AB);
    wait_idle();
    chk_beat("sb", 0, 32'h200, 4'b1000, 32'hAB000000);

    // SH at offset 1, back-to-back with the previous store
    log_q.delete();
    do_store(F3_SH, 32'h301, 32'h00001234);
    wait_idle();
    chk_beat("sh", 0, 32'h300, 4'b0110, 32'h00123400);
    chk("sh_count", {16'b0, store_count}, 32'd3);
    idle_cycles(1);

    // SW crossing a word, BEAT0 stalled 3 cycles
    log_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    c0 = store_count;
    bus.mem_ready = 1'b0;
    do_store(F3_SW, 32'h402, 32'hAABBCCDD);
    idle_cycles(3);
    bus.mem_ready = 1'b1;
    wait_idle();
    idle_cycles(1);
`ifdef STORE_SEQ_MISALIGN_EN
    chk("swx_nbeats", log_q.size(), 32'd2);
    chk_beat("swx0", 0, 32'h400, 4'b1100, 32'hCCDD0000);
    chk_beat("swx1", 1, 32'h404, 4'b0011, 32'h0000AABB);
    chk("swx_done", done_cnt - d0, 32'd1);
`else
    chk("swx_nbeats", log_q.size(), 32'd0);
    chk("swx_err", err_cnt - e0, 32'd1);
    chk("swx_count", {16'b0, store_count}, {16'b0, c0});
`endif

    // SW crossing the top of the address space
    log_q.delete();
    e0 = err_cnt;
    c0 = store_count;
    do_store(F3_SW, 32'hFFFFFFFE, 32'h11223344);
    wait_idle();
    idle_cycles(1);
`ifdef STORE_SEQ_MISALIGN_EN
    chk_beat("wrap0", 0, 32'hFFFFFFFC, 4'b1100, 32'h33440000);
    chk_beat("wrap1", 1, 32'h00000000, 4'b0011, 32'h00001122);
    chk("wrap_count", {16'b0, store_count}, {16'b0, c0 + 16'd1});
`else
    chk("wrap_nbeats", log_q.size(), 32'd0);
    chk("wrap_err", err_cnt - e0, 32'd1);
    chk("wrap_count", {16'b0, store_count}, {16'b0, c0});
`endif

    // SH at offset 3 crosses; SB with upper data bytes keeps them in unmasked lanes
    log_q.delete();
    do_store(F3_SH, 32'h603, 32'h0000BEEF);
    wait_idle();
    do_store(F3_SB, 32'h701, 32'h123456AB);
    wait_idle();
    idle_cycles(1);
`ifdef STORE_SEQ_MISALIGN_EN
    chk_beat("shx0", 0, 32'h600, 4'b1000, 32'hEF000000);
    chk_beat("shx1", 1, 32'h604, 4'b0001, 32'h000000BE);
    chk_beat("sbhi", 2, 32'h700, 4'b0010, 32'h3456AB00);
`else
    chk_beat("sbhi", 0, 32'h700, 4'b0010, 32'h3456AB00);
`endif

    // illegal funct3
    log_q.delete();
    e0 = err_cnt;
    c0 = store_count;
    do_store(3'b011, 32'h800, 32'h55555555);
    chk("ill_ready", {31'b0, bus.req_ready}, 32'h1);
    idle_cycles(2);
    chk("ill_err", err_cnt - e0, 32'd1);
    chk("ill_nbeats", log_q.size(), 32'd0);
    chk("ill_count", {16'b0, store_count}, {16'b0, c0});

    // reset during a stalled BEAT0
    bus.mem_ready = 1'b0;
    do_store(F3_SW, 32'h500, 32'h0BADF00D);
    idle_cycles(2);
    chk("stall_valid", {31'b0, bus.mem_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus.mem_valid}, 32'h0);
    chk("rst_count", {16'b0, store_count}, 32'h0);
    idle_cycles(2);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    idle_cycles(1);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_valid2", {31'b0, bus.mem_valid}, 32'h0);

    // a few more back-to-back stores after reset
    for (int i = 0; i < 4; i++) begin
      do_store(F3_SB, 32'h900 + 32'(i), 32'($urandom_range(0, 255)));
      wait_idle();
    end
    idle_cycles(2);
    chk("final_count", {16'b0, store_count}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
